// File: rtl/mem_access_unit.sv
// Memory-stage unit: word-addressed data memory plus the MEM/WB output register.
// Define MEM_WAIT_STATES_EN to add the IDLE/WAIT/DONE wait-state sequencer; without it every access is single-cycle.
//
// state | meaning
// IDLE  | no access in flight; a memory op raises freeze immediately
// WAIT  | wait states running, counter advancing, freeze held
// DONE  | freeze released; write commits and output register loads at the closing edge
module mem_access_unit #(
    parameter int MEM_BASE    = 1024,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_enable_in,
    input  logic        mem_read_enable_in,
    input  logic        mem_write_enable_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] val_rm_in,
    output logic        freeze,
    output logic        wb_enable_out,
    output logic        mem_read_enable_out,
    output logic [3:0]  dest_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out
);
    localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] BASE_A  = 32'(MEM_BASE);
    localparam logic [31:0] LIMIT_A = 32'(MEM_BASE + 4 * MEM_DEPTH);

    logic [31:0]      mem_q [MEM_DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic             freeze_int;
    logic             wr_commit;

    logic             wb_q, wb_d;
    logic             rd_q, rd_d;
    logic [3:0]       dest_q, dest_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdata_q, mdata_d;

    always_comb begin
        in_range = (alu_out_in >= BASE_A) && (alu_out_in < LIMIT_A);
        word_idx = IDX_W'((alu_out_in - BASE_A) >> 2);
        rd_word  = in_range ? mem_q[word_idx] : 32'd0;
    end

`ifdef MEM_WAIT_STATES_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_op;
    logic       freeze_raw;

    always_comb begin
        mem_op     = mem_read_enable_in | mem_write_enable_in;
        state_d    = state_q;
        cnt_d      = cnt_q;
        freeze_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    freeze_raw = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = (WAIT_CYCLES <= 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                freeze_raw = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                // The IDLE cycle already counts as one of the frozen cycles
                if (cnt_d == 4'(WAIT_CYCLES - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        freeze_int = freeze_raw & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb freeze_int = 1'b0;
`endif

    assign freeze = freeze_int;

    always_comb begin
        wr_commit = mem_write_enable_in & in_range & ~freeze_int & rst;
        wb_d      = 1'b0;
        rd_d      = 1'b0;
        dest_d    = 4'd0;
        alu_d     = 32'd0;
        mdata_d   = 32'd0;
        if (!freeze_int) begin
            wb_d    = wb_enable_in;
            rd_d    = mem_read_enable_in;
            dest_d  = dest_in;
            alu_d   = alu_out_in;
            mdata_d = (mem_read_enable_in && !mem_write_enable_in) ? rd_word : 32'd0;
        end
    end

    // Memory is deliberately not reset; its contents survive rst
    always_ff @(posedge clk) begin
        if (wr_commit) mem_q[word_idx] <= val_rm_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= 1'b0;
            rd_q    <= 1'b0;
            dest_q  <= 4'd0;
            alu_q   <= 32'd0;
            mdata_q <= 32'd0;
        end else begin
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            mdata_q <= mdata_d;
        end
    end

    assign wb_enable_out       = wb_q;
    assign mem_read_enable_out = rd_q;
    assign dest_out            = dest_q;
    assign alu_res_out         = alu_q;
    assign mem_data_out        = mdata_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_BASE, default 1024, byte address of data-memory word 0.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, number of 32-bit data-memory words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 3, access wait states, legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports wb_enable_in, mem_read_enable_in, mem_write_enable_in, inputs, 1 bit each, the EXE-register control outputs.
REQ-007 SHALL have port dest_in, input, 4 bits, destination register.
REQ-008 SHALL have port alu_out_in, input, 32 bits, ALU result and byte address.
REQ-009 SHALL have port val_rm_in, input, 32 bits, store data.
REQ-010 SHALL have port freeze, output, 1 bit, upstream stall request.
REQ-011 SHALL have ports wb_enable_out, mem_read_enable_out, outputs, 1 bit each, registered controls toward WB.
REQ-012 SHALL have port dest_out, output, 4 bits, registered destination register.
REQ-013 SHALL have ports alu_res_out and mem_data_out, outputs, 32 bits each, registered ALU result and load data.

Function
REQ-014 SHALL compute the word index as (alu_out_in - MEM_BASE) >> 2; the address is in range only when MEM_BASE <= alu_out_in < MEM_BASE + 4*MEM_DEPTH.
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 SHALL, in IDLE with mem_read_enable_in or mem_write_enable_in high, drive freeze=1 combinationally in the same cycle, clear the counter, and go to WAIT.
REQ-017 SHALL, in WAIT, hold freeze=1 and increment the counter each cycle, then go to DONE in the cycle after the counter equals WAIT_CYCLES-1.
REQ-018 SHALL, in DONE, drive freeze=0, commit any write to memory at the closing edge, load the output register, and return to IDLE.
REQ-019 SHALL therefore take WAIT_CYCLES+1 cycles per memory operation, with freeze high for the first WAIT_CYCLES of them.
REQ-020 SHALL pass an instruction with no memory operation through in one cycle, with freeze=0 and no FSM activity.
REQ-021 SHALL, on any edge where freeze=1, load a bubble into the output register: all control outputs 0, data outputs 0.
REQ-022 SHALL otherwise register wb_enable_in, mem_read_enable_in, dest_in and alu_out_in to their outputs, and load mem_data_out with the addressed word on a read.
REQ-023 SHALL rely on upstream holding all inputs stable while freeze=1.
REQ-024 SHALL ignore out-of-range writes, and SHALL return 0 on mem_data_out for out-of-range reads.
REQ-025 SHALL, when read and write enables are both high, perform the write and set mem_data_out to 0.
REQ-026 SHALL perform back-to-back memory operations with no idle cycle between them; DONE goes to IDLE, and IDLE immediately re-freezes.

Reset
REQ-027 SHALL, on rst low at any time, force the FSM to IDLE, the counter to 0, freeze to 0, and all registered outputs to 0.
REQ-028 SHALL abort a pending write on reset mid-operation without modifying memory.
REQ-029 SHALL leave memory contents unaffected by reset; they are undefined at power-up.

Configuration
REQ-030 SHALL, with macro MEM_WAIT_STATES_EN defined, implement REQ-015..REQ-019 and REQ-026.
REQ-031 SHALL, without MEM_WAIT_STATES_EN, complete every memory operation in one cycle, tie freeze to 0, and omit the FSM and counter.

Verification
REQ-032 SHALL cover: write addr 1028 data 0xDEADBEEF with WAIT_CYCLES=3 -> freeze high exactly 3 cycles, then a read of 1028 gives mem_data_out=0xDEADBEEF.
REQ-033 SHALL cover: non-memory op with wb=1, dest=5, alu=0x1234 -> next edge wb_enable_out=1, dest_out=5, alu_res_out=0x1234, freeze never high.
REQ-034 SHALL cover: read addr 1024+256 (out of range) -> mem_data_out=0, and a write to 1020 leaves all memory words unchanged.
REQ-035 SHALL cover: rst low during WAIT of a write to 1032 data 0x55 -> outputs 0, FSM IDLE, word at 1032 not 0x55.
REQ-036 SHALL cover: two consecutive writes to 1024 and 1028 -> 8 cycles total, freeze low exactly one cycle between them.
REQ-037 SHALL cover: build without MEM_WAIT_STATES_EN, read addr 1028 -> freeze constant 0, data valid one edge later.
